// File: rtl/memory_access_stage.sv
// MEM stage of the 16-bit pipelined CPU: issues loads/stores on a req/ack port and feeds MEM/WB.
// Optional build macro MEM_TIMEOUT_EN adds a bounded wait on mem_ack with a sticky err_out.
module memory_access_stage #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbs_in,
    input  logic              wme_in,
    input  logic              mm_in,
    input  logic              wm_in,
    input  logic              ni_in,
    input  logic [DATA_W-1:0] ALUresult_in,
    input  logic [DATA_W-1:0] memData_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wbs_out,
    output logic              wm_out,
    output logic              ni_out,
    output logic [DATA_W-1:0] wbData_out,
    output logic              err_out,
    output logic              o_state_dbg
);

    // Handshake: mem_req rises with a new access and stays high, with we/addr/wdata
    // frozen, until the edge after the single-cycle mem_ack pulse (or the timeout).
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_op;
    logic   w_issue;
    logic   w_complete;
    logic   w_pass;
    logic   w_timeout;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_wbs;
    logic              r_wm;
    logic              r_ni;
    logic [DATA_W-1:0] r_wb_data;

    if (ADDR_W > DATA_W || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("memory_access_stage: ADDR_W must not exceed DATA_W and TIMEOUT_CYCLES must be >= 1");
    end

    assign w_op = wme_in | mm_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_op) w_next_state = S_WAIT;
            S_WAIT:  if (mem_ack || w_timeout) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        stall_out  = 1'b0;
        w_issue    = 1'b0;
        w_complete = 1'b0;
        w_pass     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_op) begin
                    stall_out = 1'b1;
                    w_issue   = 1'b1;
                end else begin
                    w_pass = 1'b1;
                end
            end
            S_WAIT: begin
                // A timed-out access releases the stall so the instruction is dropped.
                if (mem_ack) begin
                    w_complete = 1'b1;
                end else if (!w_timeout) begin
                    stall_out = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wbs       <= 1'b0;
            r_wm        <= 1'b0;
            r_ni        <= 1'b0;
            r_wb_data   <= '0;
        end else begin
            if (w_issue) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= wme_in;
                r_mem_addr  <= ALUresult_in[ADDR_W-1:0];
                r_mem_wdata <= memData_in;
            end else if (w_complete || w_timeout) begin
                r_mem_req <= 1'b0;
            end

            if (w_pass || w_complete) begin
                r_wbs <= wbs_in;
                r_wm  <= wm_in;
                r_ni  <= ni_in;
            end else begin
                r_wbs <= 1'b0;
                r_wm  <= 1'b0;
                r_ni  <= 1'b0;
            end

            // Only a pure load takes memory data; a combined load+store writes back the ALU value.
            if (w_pass) begin
                r_wb_data <= ALUresult_in;
            end else if (w_complete) begin
                r_wb_data <= (mm_in && !wme_in) ? mem_rdata : ALUresult_in;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 4) ? 4 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;

    // The counter holds the number of WAIT cycles already spent, so the access gives up
    // at the end of the TIMEOUT_CYCLES-th WAIT cycle.
    assign w_timeout = (r_state == S_WAIT) && !mem_ack &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_issue) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_out = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_out   = 1'b0;
`endif

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign wbs_out     = r_wbs;
    assign wm_out      = r_wm;
    assign ni_out      = r_ni;
    assign wbData_out  = r_wb_data;
    assign o_state_dbg = r_state;

endmodule
